// File: rtl/motor_ramp.sv
// motor_ramp
// Slew-rate limited speed controller for a brushed motor behind an H-bridge.
// A signed 6-bit target speed is accepted over a valid/ready handshake and the
// current speed walks toward it by one unit per prescaler tick. A reversal
// always passes through zero and parks there for ZERO_HOLD cycles so the
// bridge never sees an instantaneous direction flip. A watchdog forces the
// target to zero if no command is accepted for WDOG cycles.
//
// Ports
//   clk          : single clock, rising edge
//   reset_n      : asynchronous active-low reset
//   cmd_valid    : cmd_speed holds a command
//   cmd_ready    : block will take a command on this edge (registered)
//   cmd_speed    : two's-complement target speed, -32 is treated as -31
//   dir          : 1 = forward (positive speed), 0 = reverse; held at zero
//   on           : motor enable, 1 whenever current speed is nonzero
//   duty_cycle   : magnitude of current speed
//   wdog_tripped : sticky, set on watchdog expiry, cleared by a new command
//   state_dbg    : current FSM state (0 = RUN, 1 = HOLD)
//
// Handshake: a command transfers on every rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready does not depend on cmd_valid. A producer may
// hold cmd_valid high while cmd_ready is low; nothing is taken until ready.

module motor_ramp #(
  parameter logic [15:0] RAMP_DIV  = 16'd50000,
  parameter logic [15:0] ZERO_HOLD = 16'd1000,
  parameter logic [25:0] WDOG      = 26'd50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [5:0] cmd_speed,
  output logic       dir,
  output logic       on,
  output logic [4:0] duty_cycle,
  output logic       wdog_tripped,
  output logic       state_dbg
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       presc_q, presc_d;
  logic [15:0]       hold_q, hold_d;
  logic [25:0]       wd_q, wd_d;
  logic signed [5:0] cur_q, cur_d;
  logic signed [5:0] tgt_q, tgt_d;
  logic signed [5:0] cmd_clamped;
  logic              dir_q, dir_d;
  logic              on_q, on_d;
  logic [4:0]        duty_q, duty_d;
  logic              rdy_q, rdy_d;
  logic              trip_q, trip_d;
  logic              accept;
  logic              tick;

  always_comb begin
    accept      = cmd_valid && rdy_q;
    tick        = (state_q == RUN) && (presc_q == RAMP_DIV - 16'd1);
    // -32 has no positive mirror in 6 bits, so the range is made symmetric.
    cmd_clamped = (cmd_speed == 6'b100000) ? 6'sb100001 : $signed(cmd_speed);

    state_d = state_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    trip_d  = trip_q;

    // Watchdog counter saturates so the trip condition stays asserted.
    if (accept) begin
      wd_d = 26'd0;
    end else if (wd_q == WDOG) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + 26'd1;
    end

    // An accepted command wins over a coincident watchdog expiry.
    if (accept) begin
      tgt_d  = cmd_clamped;
      trip_d = 1'b0;
    end else if (wd_d == WDOG) begin
      tgt_d  = 6'sd0;
      trip_d = 1'b1;
    end

    case (state_q)
      RUN: begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        if (tick) begin
          // Stepping uses the registered target, so a command accepted on
          // this same edge only affects later ticks.
          if (tgt_q > cur_q) begin
            cur_d = cur_q + 6'sd1;
          end else if (tgt_q < cur_q) begin
            cur_d = cur_q - 6'sd1;
          end
          // Reached zero on the way to the opposite sign: park there.
          if ((cur_q != 6'sd0) && (cur_d == 6'sd0) && (tgt_q != 6'sd0) &&
              (tgt_q[5] != cur_q[5])) begin
            state_d = HOLD;
            hold_d  = 16'd0;
            presc_d = 16'd0;
          end
        end
      end
      HOLD: begin
        // Prescaler parked at 0 so the first step after the hold comes a
        // full RAMP_DIV cycles after re-entering RUN.
        presc_d = 16'd0;
        if (hold_q == ZERO_HOLD - 16'd1) begin
          state_d = RUN;
          hold_d  = 16'd0;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Output registers track the next speed so they update with cur_speed.
    duty_d = cur_d[5] ? (5'd0 - cur_d[4:0]) : cur_d[4:0];
    on_d   = (cur_d != 6'sd0);
    dir_d  = on_d ? ~cur_d[5] : dir_q;
    rdy_d  = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      presc_q <= 16'd0;
      hold_q  <= 16'd0;
      wd_q    <= 26'd0;
      cur_q   <= 6'sd0;
      tgt_q   <= 6'sd0;
      dir_q   <= 1'b0;
      on_q    <= 1'b0;
      duty_q  <= 5'd0;
      rdy_q   <= 1'b1;
      trip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      wd_q    <= wd_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      on_q    <= on_d;
      duty_q  <= duty_d;
      rdy_q   <= rdy_d;
      trip_q  <= trip_d;
    end
  end

  assign cmd_ready    = rdy_q;
  assign dir          = dir_q;
  assign on           = on_q;
  assign duty_cycle   = duty_q;
  assign wdog_tripped = trip_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_motor_ramp.sv
// Directed testbench for motor_ramp with RAMP_DIV=4, ZERO_HOLD=8, WDOG=100.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_motor_ramp;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [5:0] cmd_speed;
  logic       dir;
  logic       on;
  logic [4:0] duty_cycle;
  logic       wdog_tripped;
  logic       state_dbg;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  motor_ramp #(
    .RAMP_DIV (16'd4),
    .ZERO_HOLD(16'd8),
    .WDOG     (26'd100)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_speed   (cmd_speed),
    .dir         (dir),
    .on          (on),
    .duty_cycle  (duty_cycle),
    .wdog_tripped(wdog_tripped),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic do_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_cmd(input string tag, input int v);
    int n;
    cmd_speed = 6'(v);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_ready_tmo"}, n, 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_change(input string tag, output int n);
    logic [4:0] prev;
    prev = duty_cycle;
    n = 0;
    while (duty_cycle == prev && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check({tag, "_step_tmo"}, n, 0);
  endtask

  // Waits for the next duty change; exp_gap < 0 means "at most one period".
  task automatic step_chk(input string tag, input int exp_duty, input int exp_dir,
                          input int exp_gap);
    int n;
    wait_change(tag, n);
    if (exp_gap < 0) check({tag, "_gap_le4"}, int'(n <= 4), 1);
    else             check({tag, "_gap"}, n, exp_gap);
    check({tag, "_duty"}, int'(duty_cycle), exp_duty);
    check({tag, "_dir"}, int'(dir), exp_dir);
    check({tag, "_on"}, int'(on), int'(exp_duty != 0));
  endtask

  // Counts falling edges spent with cmd_ready low; also counts any cycle in
  // that window where the motor was enabled.
  task automatic count_hold(output int n, output int on_seen);
    n = 0;
    on_seen = 0;
    while (!cmd_ready && n < 40) begin
      if (on) on_seen++;
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int on_seen;
    int e;
    bit first;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_speed = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dir", int'(dir), 0);
    check("rst_on", int'(on), 0);
    check("rst_duty", int'(duty_cycle), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_wdog", int'(wdog_tripped), 0);
    check("rst_state", int'(state_dbg), 0);
    reset_n = 1'b1;

    // Ramp up 0 -> +5
    send_cmd("up", 5);
    for (int k = 1; k <= 5; k++) exp_q.push_back(5'(k));
    first = 1'b1;
    while (exp_q.size() > 0) begin
      e = int'(exp_q.pop_front());
      step_chk("up", e, 1, first ? -1 : 4);
      first = 1'b0;
    end
    idle(12);
    check("up_stay", int'(duty_cycle), 5);

    // Reversal +5 -> -3 through an 8-cycle zero hold
    send_cmd("rev", -3);
    for (int k = 4; k >= 0; k--) exp_q.push_back(5'(k));
    first = 1'b1;
    while (exp_q.size() > 0) begin
      e = int'(exp_q.pop_front());
      step_chk("rev_down", e, 1, first ? -1 : 4);
      first = 1'b0;
    end
    check("rev_hold_ready", int'(cmd_ready), 0);
    check("rev_hold_state", int'(state_dbg), 1);
    count_hold(n, on_seen);
    check("rev_hold_len", n, 8);
    check("rev_hold_on", on_seen, 0);
    for (int k = 1; k <= 3; k++) step_chk("rev_up", k, 0, 4);
    idle(12);
    check("rev_stay", int'(duty_cycle), 3);

    // Backpressure A: -3 -> +1; +7 offered during hold but withdrawn before
    // RUN, so the target must remain +1.
    send_cmd("bpa", 1);
    step_chk("bpa_dn", 2, 0, -1);
    step_chk("bpa_dn", 1, 0, 4);
    step_chk("bpa_dn", 0, 0, 4);
    cmd_valid = 1'b1;
    cmd_speed = 6'd7;
    for (int i = 0; i < 7; i++) begin
      check("bpa_hold_ready", int'(cmd_ready), 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("bpa_hold_ready_last", int'(cmd_ready), 0);
    @(negedge clk);
    check("bpa_run_ready", int'(cmd_ready), 1);
    step_chk("bpa_up", 1, 1, 4);
    idle(12);
    check("bpa_target_kept", int'(duty_cycle), 1);

    // Backpressure B: +1 -> -2; +7 held through hold, taken on first RUN cycle
    send_cmd("bpb", -2);
    step_chk("bpb_dn", 0, 1, -1);
    cmd_valid = 1'b1;
    cmd_speed = 6'd7;
    count_hold(n, on_seen);
    check("bpb_hold_len", n, 8);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    step_chk("bpb_up", 1, 1, 3);
    step_chk("bpb_up", 2, 1, 4);
    step_chk("bpb_up", 3, 1, 4);

    // Asynchronous reset mid-ramp, between clock edges
    #2 reset_n = 1'b0;
    #1;
    check("areset_dir", int'(dir), 0);
    check("areset_on", int'(on), 0);
    check("areset_duty", int'(duty_cycle), 0);
    check("areset_ready", int'(cmd_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    send_cmd("resume", 1);
    step_chk("resume", 1, 1, -1);

    // Clamp: -32 from rest ends at -31. Re-sent midway to keep the watchdog fed.
    do_reset();
    send_cmd("clamp", -32);
    idle(60);
    send_cmd("clamp_refeed", -32);
    n = 0;
    while (duty_cycle != 5'd31 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("clamp_reach", int'(n < 100), 1);
    check("clamp_duty", int'(duty_cycle), 31);
    check("clamp_dir", int'(dir), 0);
    check("clamp_on", int'(on), 1);
    idle(12);
    check("clamp_stay", int'(duty_cycle), 31);
    check("clamp_wdog", int'(wdog_tripped), 0);

    // Watchdog: +5 then silence for 100 cycles
    do_reset();
    send_cmd("wd", 5);
    n = 0;
    while (!wdog_tripped && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wd_trip_time", n, 100);
    check("wd_duty_at_trip", int'(duty_cycle), 5);
    n = 0;
    while (on && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("wd_ramp_steps_bound", int'(n <= 20), 1);
    check("wd_down_duty", int'(duty_cycle), 0);
    check("wd_sticky", int'(wdog_tripped), 1);
    check("wd_no_hold", int'(cmd_ready), 1);
    idle(10);
    check("wd_stay_off", int'(on), 0);
    send_cmd("wd_cmd", 2);
    check("wd_clear", int'(wdog_tripped), 0);
    step_chk("wd_up", 1, 1, -1);
    step_chk("wd_up", 2, 1, 4);
    idle(12);
    check("wd_stay", int'(duty_cycle), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_ramp.md
MOTOR_RAMP -- requirements
Module: motor_ramp

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 16'd50000, meaning clock cycles per ramp step (1 ms at 50 MHz); legal range >= 1.
REQ-002 SHALL have parameter ZERO_HOLD, default 16'd1000, meaning clock cycles held at zero before a direction reversal; legal range >= 1.
REQ-003 SHALL have parameter WDOG, default 26'd50000000, meaning clock cycles without an accepted command before the watchdog trips; legal range >= 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1 bit: cmd_speed is valid.
REQ-007 SHALL have port cmd_ready, output, 1 bit: block accepts a command this cycle.
REQ-008 SHALL have port cmd_speed, input, 6 bits: two's-complement target speed.
REQ-009 SHALL have port dir, output, 1 bit: motor direction, feeding the downstream H-bridge controller.
REQ-010 SHALL have port on, output, 1 bit: motor enable, feeding the downstream H-bridge controller.
REQ-011 SHALL have port duty_cycle, output, 5 bits: PWM magnitude, feeding the downstream H-bridge controller.
REQ-012 SHALL have port wdog_tripped, output, 1 bit: sticky watchdog flag.

Function
REQ-013 SHALL accept a command on any rising edge where cmd_valid && cmd_ready; the accepted value loads the target register (signed 6-bit).
REQ-014 SHALL clamp an accepted cmd_speed of -32 to -31, giving a target range of -31..+31.
REQ-015 SHALL hold a signed 6-bit cur_speed register and drive outputs as registers updated on the same edge as cur_speed: duty_cycle = |cur_speed|, on = (cur_speed != 0), dir = 1 when cur_speed > 0, dir = 0 when cur_speed < 0.
REQ-016 SHALL hold dir at its last value when cur_speed = 0.
REQ-017 SHALL run a prescaler counting 0..RAMP_DIV-1 and issue a one-cycle tick on wrap; the prescaler runs in RUN only and restarts at 0 on entry to RUN.
REQ-018 SHALL implement two states, RUN and HOLD; cmd_ready = 1 in RUN and 0 in HOLD (registered).
REQ-019 SHALL, on a tick in RUN, step cur_speed by exactly 1 toward target; if cur_speed == target, no change.
REQ-020 SHALL, when cur_speed is nonzero and target is nonzero with opposite sign, step toward 0 first; never skip zero.
REQ-021 SHALL, when a step makes cur_speed = 0 and target is nonzero with sign opposite to the prior cur_speed, enter HOLD.
REQ-022 SHALL hold cur_speed = 0 in HOLD for exactly ZERO_HOLD cycles, then return to RUN.
REQ-023 SHALL, on a tick coinciding with command acceptance, step using the old target; the new target takes effect from the next cycle.
REQ-024 SHALL maintain a watchdog counter that clears on every accepted command and otherwise increments, saturating at WDOG.
REQ-025 SHALL, when the watchdog counter reaches WDOG, force target to 0 and set wdog_tripped; ramp-down proceeds at the normal rate.
REQ-026 SHALL clear wdog_tripped only on an accepted command; if acceptance and expiry coincide, the command wins (counter cleared, flag 0, target loaded).
REQ-027 SHALL, when target is forced to 0 during HOLD, return to RUN after the hold and remain at 0.

Reset
REQ-028 SHALL, on reset_n low, immediately and asynchronously drive: cur_speed = 0, target = 0, state = RUN, prescaler = 0, watchdog counter = 0, dir = 0, on = 0, duty_cycle = 0, cmd_ready = 1, wdog_tripped = 0.
REQ-029 SHALL, on reset mid-ramp or mid-HOLD, discard all progress; operation resumes from the reset state on the first edge after release.

Verification (bench parameters: RAMP_DIV=4, ZERO_HOLD=8, WDOG=100)
REQ-030 SHALL verify ramp-up: after reset, command +5 -> dir=1, on=1, duty_cycle steps 1,2,3,4,5, one step every 4 cycles, then holds at 5.
REQ-031 SHALL verify reversal: at +5, command -3 -> duty_cycle 4..0 at 4-cycle steps, then on=0 and cmd_ready=0 for 8 cycles, then dir=0 with duty_cycle 1,2,3.
REQ-032 SHALL verify clamp: command -32 from 0 -> ramps to dir=0, duty_cycle=31 and stops there.
REQ-033 SHALL verify watchdog: at +5 with no command for 100 cycles -> wdog_tripped=1 and ramp to 0; then command +2 -> wdog_tripped=0 and ramp to 2.
REQ-034 SHALL verify HOLD backpressure: cmd_valid with +7 during HOLD -> not accepted and target unchanged; the same command is accepted on the first RUN cycle.
REQ-035 SHALL verify async reset: reset_n pulsed low mid-ramp with no clock edge -> dir, on, duty_cycle all 0 at once.
